// File: rtl/ula_param.sv
// Parametrised accumulator ALU with valid/ready instruction handshake and zero/carry flags.
// Optional shift-add multiplier (opcode C) enabled by defining ULA_PARAM_MUL_EN.
module ula_param #(
  parameter int DATA_W = 8,
  parameter int OPND_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPND_W+3:0]   barramentoDados,
  output logic                busy,
  output logic [DATA_W-1:0]   ledsRegAcumulador,
  output logic [DATA_W-1:0]   ledsRegSaida,
  output logic                flag_zero,
  output logic                flag_carry
);

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_CLR = 4'hB;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm_ext;
  logic              accept;
  logic [DATA_W:0]   sum;
  logic              wr_acc;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] saida_q, saida_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  assign opcode  = barramentoDados[OPND_W+3:OPND_W];
  assign imm_ext = DATA_W'(barramentoDados[OPND_W-1:0]);
  assign accept  = instr_valid & instr_ready;

`ifdef ULA_PARAM_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam int PW    = DATA_W + OPND_W;
  localparam int CNT_W = $clog2(OPND_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OPND_W - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;   // multiplicand pre-shifted by cnt
  logic [OPND_W-1:0] mplier_q, mplier_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign busy        = (state_q == S_MUL);
  assign instr_ready = (state_q == S_IDLE) & ~reset;
`else
  assign busy        = 1'b0;
  assign instr_ready = ~reset;
`endif

  always_comb begin
    acc_d   = acc_q;
    saida_d = saida_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    sum     = '0;
    wr_acc  = 1'b0;
`ifdef ULA_PARAM_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
`endif
    if (accept) begin
      case (opcode)
        OP_LDI: begin acc_d = imm_ext; wr_acc = 1'b1; end
        OP_ADD: begin
          sum     = {1'b0, acc_q} + {1'b0, imm_ext};
          acc_d   = sum[DATA_W-1:0];
          carry_d = sum[DATA_W];
          wr_acc  = 1'b1;
        end
        OP_SUB: begin
          // Top bit of the extended difference is the borrow.
          sum     = {1'b0, acc_q} - {1'b0, imm_ext};
          acc_d   = sum[DATA_W-1:0];
          carry_d = sum[DATA_W];
          wr_acc  = 1'b1;
        end
        OP_AND: begin acc_d = acc_q & imm_ext; wr_acc = 1'b1; end
        OP_OR:  begin acc_d = acc_q | imm_ext; wr_acc = 1'b1; end
        OP_XOR: begin acc_d = acc_q ^ imm_ext; wr_acc = 1'b1; end
        OP_NOT: begin acc_d = ~acc_q;          wr_acc = 1'b1; end
        OP_SHL: begin
          carry_d = acc_q[DATA_W-1];
          acc_d   = acc_q << 1;
          wr_acc  = 1'b1;
        end
        OP_SHR: begin
          carry_d = acc_q[0];
          acc_d   = acc_q >> 1;
          wr_acc  = 1'b1;
        end
        OP_OUT: saida_d = acc_q;
        OP_CLR: begin acc_d = '0; carry_d = 1'b0; wr_acc = 1'b1; end
`ifdef ULA_PARAM_MUL_EN
        OP_MUL: begin
          state_d  = S_MUL;
          mcand_d  = PW'(acc_q);
          mplier_d = barramentoDados[OPND_W-1:0];
          prod_d   = '0;
          cnt_d    = '0;
        end
`endif
        default: ;
      endcase
    end
    if (wr_acc) zero_d = (acc_d == '0);
`ifdef ULA_PARAM_MUL_EN
    if (state_q == S_MUL) begin
      prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        acc_d   = prod_d[DATA_W-1:0];
        carry_d = |prod_d[PW-1:DATA_W];
        zero_d  = (prod_d[DATA_W-1:0] == '0);
        state_d = S_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      saida_q <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`ifdef ULA_PARAM_MUL_EN
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      acc_q   <= acc_d;
      saida_q <= saida_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
`ifdef ULA_PARAM_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ledsRegAcumulador = acc_q;
  assign ledsRegSaida      = saida_q;
  assign flag_zero         = zero_q;
  assign flag_carry        = carry_q;

endmodule

// File: tb/tb_ula_param.sv
// Self-checking bench for ula_param (DATA_W=8, OPND_W=4): vector table, MUL/reset sequences,
// and randomized instructions against an arithmetic reference model.
module tb_ula_param;
  localparam int DATA_W = 8;
  localparam int OPND_W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] bus = 8'h00;
  logic       busy;
  logic [7:0] leds_acc, leds_saida;
  logic       flag_zero, flag_carry;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers
  int m_acc, m_saida, m_z, m_c;

  typedef struct {
    logic [7:0] word;
    logic [7:0] acc;
    logic [7:0] saida;
    logic       z;
    logic       c;
  } vec_t;

  ula_param #(.DATA_W(DATA_W), .OPND_W(OPND_W)) dut (
    .clock(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .barramentoDados(bus),
    .busy(busy),
    .ledsRegAcumulador(leds_acc),
    .ledsRegSaida(leds_saida),
    .flag_zero(flag_zero),
    .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int acc, input int saida, input int z, input int c);
    check({tag, ".acc"},   32'(leds_acc),   32'(acc));
    check({tag, ".saida"}, 32'(leds_saida), 32'(saida));
    check({tag, ".zero"},  32'(flag_zero),  32'(z));
    check({tag, ".carry"}, 32'(flag_carry), 32'(c));
  endtask

  task automatic model_reset();
    m_acc = 0; m_saida = 0; m_z = 0; m_c = 0;
  endtask

  task automatic model_step(input logic [7:0] w);
    int op, imm, r;
    bit wr;
    op = int'(w) / 16;
    imm = int'(w) % 16;
    wr = 1'b1;
    case (op)
      1: m_acc = imm;
      2: begin r = m_acc + imm; m_c = (r > 255); m_acc = r % 256; end
      3: begin m_c = (imm > m_acc); m_acc = (m_acc - imm + 256) % 256; end
      4: m_acc = m_acc & imm;
      5: m_acc = m_acc | imm;
      6: m_acc = m_acc ^ imm;
      7: m_acc = 255 - m_acc;
      8: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
      9: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
      10: begin m_saida = m_acc; wr = 1'b0; end
      11: begin m_acc = 0; m_c = 0; end
`ifdef ULA_PARAM_MUL_EN
      12: begin r = m_acc * imm; m_c = (r > 255); m_acc = r % 256; end
`endif
      default: wr = 1'b0;
    endcase
    if (wr) m_z = (m_acc == 0);
  endtask

  // Present one word, wait for acceptance, and wait for a MUL to finish.
  task automatic exec(input logic [7:0] w);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    bus = w;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!instr_ready) begin
      errors++;
      $display("FAIL ready_timeout actual=%0b required=1 word=%02h", instr_ready, w);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
`ifdef ULA_PARAM_MUL_EN
    if (w[7:4] == 4'hC) begin
      repeat (OPND_W) @(posedge clk);
      #1;
    end
`endif
  endtask

  task automatic run(input logic [7:0] w);
    exec(w);
    model_step(w);
    $display("instr %02h -> acc=%02h saida=%02h z=%0b c=%0b", w, leds_acc, leds_saida, flag_zero, flag_carry);
    check_all($sformatf("rand_%02h", w), m_acc, m_saida, m_z, m_c);
    check("rand.busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst.ready_low", 32'(instr_ready), 32'd0);
    @(posedge clk);
    #1;
    check_all("rst", 0, 0, 0, 0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ready_low2", 32'(instr_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst.ready_high", 32'(instr_ready), 32'd1);
    model_reset();
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{8'h1F, 8'h0F, 8'h00, 1'b0, 1'b0},
      '{8'h23, 8'h12, 8'h00, 1'b0, 1'b0},
      '{8'hA0, 8'h12, 8'h12, 1'b0, 1'b0},
      '{8'h10, 8'h00, 8'h12, 1'b1, 1'b0},
      '{8'h31, 8'hFF, 8'h12, 1'b0, 1'b1},
      '{8'h21, 8'h00, 8'h12, 1'b1, 1'b1},
      '{8'h1F, 8'h0F, 8'h12, 1'b0, 1'b1},
      '{8'h80, 8'h1E, 8'h12, 1'b0, 1'b0},
      '{8'h80, 8'h3C, 8'h12, 1'b0, 1'b0},
      '{8'h80, 8'h78, 8'h12, 1'b0, 1'b0},
      '{8'h80, 8'hF0, 8'h12, 1'b0, 1'b0},
      '{8'h80, 8'hE0, 8'h12, 1'b0, 1'b1},
      '{8'hD5, 8'hE0, 8'h12, 1'b0, 1'b1},
      '{8'hE5, 8'hE0, 8'h12, 1'b0, 1'b1},
      '{8'hF5, 8'hE0, 8'h12, 1'b0, 1'b1},
      '{8'h00, 8'hE0, 8'h12, 1'b0, 1'b1},
      '{8'h91, 8'h70, 8'h12, 1'b0, 1'b0},
      '{8'h70, 8'h8F, 8'h12, 1'b0, 1'b0},
      '{8'h6F, 8'h80, 8'h12, 1'b0, 1'b0},
      '{8'h5F, 8'h8F, 8'h12, 1'b0, 1'b0},
      '{8'h43, 8'h03, 8'h12, 1'b0, 1'b0},
      '{8'h4C, 8'h00, 8'h12, 1'b1, 1'b0},
      '{8'hA0, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h28, 8'h08, 8'h00, 1'b0, 1'b0},
      '{8'hB0, 8'h00, 8'h00, 1'b1, 1'b0}
    };

    repeat (3) @(posedge clk);
    do_reset();

    foreach (vecs[i]) begin
      exec(vecs[i].word);
      $display("vec %0d instr %02h -> acc=%02h saida=%02h z=%0b c=%0b", i, vecs[i].word,
               leds_acc, leds_saida, flag_zero, flag_carry);
      check_all($sformatf("vec%0d", i), vecs[i].acc, vecs[i].saida, vecs[i].z, vecs[i].c);
    end

`ifdef ULA_PARAM_MUL_EN
    // MUL 0x0D * 0xB, with an extra instruction offered while busy
    do_reset();
    run(8'h1D);
    @(negedge clk);
    instr_valid = 1'b1;
    bus = 8'hCB;
    @(posedge clk);
    #1;
    bus = 8'h1F;
    for (int k = 0; k < OPND_W; k++) begin
      check($sformatf("mul.busy%0d", k), 32'(busy), 32'd1);
      check($sformatf("mul.ready%0d", k), 32'(instr_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    $display("mul 0D*B -> acc=%02h c=%0b busy=%0b", leds_acc, flag_carry, busy);
    check("mul.busy_done", 32'(busy), 32'd0);
    check("mul.ready_done", 32'(instr_ready), 32'd1);
    check_all("mul_0d_b", 8'h8F, 0, 0, 0);
    model_step(8'hCB);

    // MUL with discarded high bits: 0x78 * 0xF
    run(8'h1F); run(8'h80); run(8'h80); run(8'h80);
    run(8'hCF);
    check_all("mul_78_f", 8'h08, 0, 0, 1);

    // Reset during the second MUL cycle
    run(8'h1D);
    @(negedge clk);
    instr_valid = 1'b1;
    bus = 8'hCB;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("mul abort -> acc=%02h busy=%0b", leds_acc, busy);
    check_all("mul_abort", 0, 0, 0, 0);
    check("mul_abort.busy", 32'(busy), 32'd0);
    check("mul_abort.ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mul_abort.ready_after", 32'(instr_ready), 32'd1);
    model_reset();
`else
    // Opcode C is a plain NOP without the multiplier
    do_reset();
    run(8'h13);
    @(negedge clk);
    instr_valid = 1'b1;
    bus = 8'hC3;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    $display("instr C3 -> acc=%02h busy=%0b", leds_acc, busy);
    check_all("mul_off", 3, 0, 0, 0);
    for (int k = 0; k < OPND_W; k++) begin
      check($sformatf("mul_off.busy%0d", k), 32'(busy), 32'd0);
      check($sformatf("mul_off.ready%0d", k), 32'(instr_ready), 32'd1);
      @(posedge clk);
      #1;
    end
`endif

    // Randomized instructions against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      run(8'($urandom_range(0, 255)));
    end

    // Reset from an arbitrary state
    run(8'h1F);
    run(8'hA0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
